// File: rtl/mul_div_seq_if.sv
// Request/result bundle for the sequential multiply/divide unit.
// MULDIV_UNSIGNED_EN adds the is_unsigned request bit.
interface mul_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
`ifdef MULDIV_UNSIGNED_EN
  logic             is_unsigned;
`endif
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
`ifdef MULDIV_UNSIGNED_EN
    output is_unsigned,
`endif
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
`ifdef MULDIV_UNSIGNED_EN
    input  is_unsigned,
`endif
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_seq.sv
// Sequential Booth multiply / restoring divide, one step per clock.
// MULDIV_UNSIGNED_EN enables per-request unsigned operation.
module mul_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         clear,
  mul_div_seq_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             op_q;
  logic             uns_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH+1:0] acc_q;
  logic [WIDTH+1:0] m_q;
  logic [WIDTH-1:0] qr_q;
  logic             q1_q;

  logic             uns_in;
  logic             accept;
  logic             last;

`ifdef MULDIV_UNSIGNED_EN
  assign uns_in = bus.is_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  assign accept = (state_q == IDLE) && bus.start && !busy_q;
  assign last   = (cnt_q == CW'(WIDTH - 1));

  // Operand setup at accept
  logic             sa_in;
  logic             sb_in;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic [WIDTH+1:0] init_m;
  logic [WIDTH-1:0] init_q;

  always_comb begin
    sa_in    = !uns_in && bus.a[WIDTH-1];
    sb_in    = !uns_in && bus.b[WIDTH-1];
    mag_a_in = sa_in ? -bus.a : bus.a;
    mag_b_in = sb_in ? -bus.b : bus.b;
    init_m   = {2'b00, bus.a};
    init_q   = bus.b;
    if (bus.op) begin
      init_m = {2'b00, mag_b_in};
      init_q = mag_a_in;
    end else if (!uns_in) begin
      init_m = {{2{bus.a[WIDTH-1]}}, bus.a};
    end
  end

  // One iteration of either algorithm
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH+1:0] acc_n;
  logic [WIDTH-1:0] qr_n;
  logic             q1_n;

  always_comb begin
    sum = acc_q;
    unique case (1'b1)
      (qr_q[0] && !q1_q): sum = acc_q - m_q;
      (!qr_q[0] && q1_q): sum = acc_q + m_q;
      default:            sum = acc_q;
    endcase
    sh   = {acc_q[WIDTH:0], qr_q[WIDTH-1]};
    diff = sh - m_q;
    if (!op_q) begin
      acc_n = {sum[WIDTH+1], sum[WIDTH+1:1]};
      qr_n  = {sum[0], qr_q[WIDTH-1:1]};
      q1_n  = qr_q[0];
    end else if (!diff[WIDTH+1]) begin
      acc_n = diff;
      qr_n  = {qr_q[WIDTH-2:0], 1'b1};
      q1_n  = 1'b0;
    end else begin
      acc_n = sh;
      qr_n  = {qr_q[WIDTH-2:0], 1'b0};
      q1_n  = 1'b0;
    end
  end

  // Result fix-up: signs for divide, guard-bit term for unsigned multiply
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic             fix_dbz;

  always_comb begin
    sa      = !uns_q && a_q[WIDTH-1];
    sb      = !uns_q && b_q[WIDTH-1];
    fix_dbz = 1'b0;
    fix_lo  = qr_q;
    fix_hi  = acc_q[WIDTH-1:0];
    if (!op_q) begin
      if (uns_q && b_q[WIDTH-1])
        fix_hi = acc_q[WIDTH-1:0] + a_q;
    end else if (b_q == '0) begin
      fix_dbz = 1'b1;
      fix_lo  = '1;
      fix_hi  = a_q;
    end else begin
      fix_lo = (sa ^ sb) ? -qr_q : qr_q;
      fix_hi = sa ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (last) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      op_q   <= 1'b0;
      uns_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      m_q    <= '0;
      qr_q   <= '0;
      q1_q   <= 1'b0;
    end else begin
      // done is registered off DONE, so busy spans the done cycle too
      done_q <= (state_q == DONE);
      if (done_q) busy_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            op_q   <= bus.op;
            uns_q  <= uns_in;
            a_q    <= bus.a;
            b_q    <= bus.b;
            cnt_q  <= '0;
            acc_q  <= '0;
            q1_q   <= 1'b0;
            m_q    <= init_m;
            qr_q   <= init_q;
          end
        end
        CALC: begin
          acc_q <= acc_n;
          qr_q  <= qr_n;
          q1_q  <= q1_n;
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          hi_q  <= fix_hi;
          lo_q  <= fix_lo;
          dbz_q <= fix_dbz;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for mul_div_seq: directed vectors, monitor on done.
// Unsigned vectors are included when MULDIV_UNSIGNED_EN is defined.
module tb_mul_div_seq;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  mul_div_seq_if #(.WIDTH(32)) bus ();

  mul_div_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int unsigned edge_no;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned edges  = 0;

  always @(posedge clock) edges <= edges + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (clear && bus.done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
        chk({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
        chk({e.name, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
        chk({e.name, "_latency"}, 64'(edges), 64'(e.edge_no));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (bus.busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input string nm, input logic op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic uns, input logic [31:0] hi,
                       input logic [31:0] lo, input logic dbz,
                       input bit push);
    exp_t e;
    wait_idle();
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
`ifdef MULDIV_UNSIGNED_EN
    bus.is_unsigned = uns;
`else
    if (uns) chk("uns_without_feature", 64'd1, 64'd0);
`endif
    e.name    = nm;
    e.hi      = hi;
    e.lo      = lo;
    e.dbz     = dbz;
    e.edge_no = edges + 1 + 34;
    if (push) sb_q.push_back(e);
    @(negedge clock);
    bus.start = 1'b0;
    chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef MULDIV_UNSIGNED_EN
    bus.is_unsigned = 1'b0;
`endif
    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);

    issue("mul_7_m3", 1'b0, 32'd7, 32'hFFFFFFFD, 1'b0,
          32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1);
    drain();
    issue("mul_min_min", 1'b0, 32'h80000000, 32'h80000000, 1'b0,
          32'h40000000, 32'h00000000, 1'b0, 1'b1);
    drain();
    issue("mul_max_max", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0,
          32'h3FFFFFFF, 32'h00000001, 1'b0, 1'b1);
    drain();
    issue("mul_m5_m6", 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, 1'b0,
          32'h0, 32'h1E, 1'b0, 1'b1);
    drain();
    issue("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0,
          32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
    drain();
    issue("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 1'b0,
          32'h1, 32'hFFFFFFFD, 1'b0, 1'b1);
    drain();
    issue("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0,
          32'h0, 32'h80000000, 1'b0, 1'b1);
    drain();
    issue("div_5_0", 1'b1, 32'd5, 32'd0, 1'b0,
          32'h5, 32'hFFFFFFFF, 1'b1, 1'b1);
    drain();
    chk("dbz_hold", 64'(bus.div_by_zero), 64'd1);
    issue("mul_3_4", 1'b0, 32'd3, 32'd4, 1'b0,
          32'h0, 32'hC, 1'b0, 1'b1);
    drain();

    // start while busy must not disturb the running multiply
    issue("mul_ign", 1'b0, 32'd7, 32'hFFFFFFFD, 1'b0,
          32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1);
    repeat (8) @(negedge clock);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd99;
    bus.b     = 32'd5;
    @(negedge clock);
    bus.start = 1'b0;
    drain();

    // reset in the middle of an operation aborts it
    issue("abort", 1'b0, 32'd3, 32'd3, 1'b0,
          32'h0, 32'h9, 1'b0, 1'b0);
    repeat (18) @(negedge clock);
    clear = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (3) @(negedge clock);
    clear = 1'b1;
    repeat (40) @(negedge clock);
    chk("abort_no_done_hilo", {bus.hi, bus.lo}, 64'd0);
    issue("div_100_7", 1'b1, 32'd100, 32'd7, 1'b0,
          32'd2, 32'd14, 1'b0, 1'b1);
    drain();

`ifdef MULDIV_UNSIGNED_EN
    issue("udiv_max_2", 1'b1, 32'hFFFFFFFF, 32'd2, 1'b1,
          32'd1, 32'h7FFFFFFF, 1'b0, 1'b1);
    drain();
    issue("umul_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
          32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
    drain();
`endif

    repeat (4) @(negedge clock);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
